// File: rtl/mul_ctrl_pkg.sv
// Shared constants and FSM encoding for the shared-multiplier controller.
package mul_ctrl_pkg;
  localparam int unsigned MUL_WIDTH = 64;
  localparam int unsigned MUL_N_REQ = 4;
  localparam int unsigned MUL_ID_W  = $clog2(MUL_N_REQ);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStart,
    StRun,
    StResp
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// The pointer moves only when advance is high and some request is present.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] r_last;
  logic            w_found;
  int unsigned     w_k;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_k = (int'(r_last) + i) % N_REQ;
      if (!w_found && req[w_k[ID_W-1:0]]) begin
        w_found                = 1'b1;
        gnt[w_k[ID_W-1:0]]     = 1'b1;
        idx                    = w_k[ID_W-1:0];
      end
    end
  end

  // Start at N_REQ-1 so the first search after reset begins at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= ID_W'(N_REQ - 1);
    end else if (advance && w_found) begin
      r_last <= idx;
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one signed multiplier among N_REQ clients: arbitrate, clear/start, await done, respond.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the multiplier and respond with 0.
module mul_share_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = MUL_N_REQ,
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_multiplier,
  input  logic [N_REQ*WIDTH-1:0] req_multiplicand,
  output logic [N_REQ-1:0]       gnt,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [2*WIDTH-1:0]     resp_result,
  output logic                   busy,
  output logic                   mul_op_clear,
  output logic                   mul_op_start,
  output logic [WIDTH-1:0]       mul_multiplier,
  output logic [WIDTH-1:0]       mul_multiplicand,
  input  logic                   mul_op_done,
  input  logic [2*WIDTH-1:0]     mul_result
);

  state_e             r_state;
  logic               r_resp_valid;
  logic               r_op_clear;
  logic               r_op_start;
  logic [ID_W-1:0]    r_resp_id;
  logic [2*WIDTH-1:0] r_resp_result;
  logic [WIDTH-1:0]   r_mul_multiplier;
  logic [WIDTH-1:0]   r_mul_multiplicand;

  logic               w_idle;
  logic [N_REQ-1:0]   w_arb_gnt;
  logic [ID_W-1:0]    w_arb_idx;
  logic [WIDTH-1:0]   w_win_a;
  logic [WIDTH-1:0]   w_win_b;

  assign w_idle  = (r_state == StIdle) && !reset;
  assign w_win_a = req_multiplier[w_arb_idx*WIDTH +: WIDTH];
  assign w_win_b = req_multiplicand[w_arb_idx*WIDTH +: WIDTH];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (w_idle),
    .gnt     (w_arb_gnt),
    .idx     (w_arb_idx)
  );

`ifdef MUL_ZERO_BYPASS_EN
  logic w_win_zero;
  assign w_win_zero = (w_win_a == '0) || (w_win_b == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= StIdle;
      r_resp_valid       <= 1'b0;
      r_op_clear         <= 1'b0;
      r_op_start         <= 1'b0;
      r_resp_id          <= '0;
      r_resp_result      <= '0;
      r_mul_multiplier   <= '0;
      r_mul_multiplicand <= '0;
    end else begin
      r_op_clear <= 1'b0;
      r_op_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (|req) begin
            r_resp_id <= w_arb_idx;
`ifdef MUL_ZERO_BYPASS_EN
            if (w_win_zero) begin
              r_resp_result <= '0;
              r_resp_valid  <= 1'b1;
              r_state       <= StResp;
            end else begin
              r_mul_multiplier   <= w_win_a;
              r_mul_multiplicand <= w_win_b;
              r_op_clear         <= 1'b1;
              r_state            <= StClear;
            end
`else
            r_mul_multiplier   <= w_win_a;
            r_mul_multiplicand <= w_win_b;
            r_op_clear         <= 1'b1;
            r_state            <= StClear;
`endif
          end
        end
        StClear: begin
          r_op_start <= 1'b1;
          r_state    <= StStart;
        end
        StStart: r_state <= StRun;
        StRun: begin
          if (mul_op_done) begin
            r_resp_result <= mul_result;
            r_resp_valid  <= 1'b1;
            r_state       <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt              = w_idle ? w_arb_gnt : '0;
  assign busy             = (r_state != StIdle);
  assign resp_valid       = r_resp_valid;
  assign resp_id          = r_resp_id;
  assign resp_result      = r_resp_result;
  // The multiplier is held cleared for the whole reset window.
  assign mul_op_clear     = r_op_clear | reset;
  assign mul_op_start     = r_op_start;
  assign mul_multiplier   = r_mul_multiplier;
  assign mul_multiplicand = r_mul_multiplicand;

endmodule
